// File: rtl/reflet_rom_loader.sv
// Boot loader: validates the "ASRM" header of a synchronous byte ROM, then
// streams the whole image into a RAM write port while the CPU is held off.
//
// state | meaning
// IDLE  | waiting for start after reset
// MAGIC | reading header bytes 0..3 and comparing with MAGIC
// COPY  | streaming ROM bytes 0..ROM_SIZE-1 into RAM
// DONE  | image copied, done held until next start
// ERROR | header mismatch, error held until next start
module reflet_rom_loader #(
  parameter int                    ADDR_WIDTH = 8,
  parameter int                    ROM_SIZE   = 256,
  parameter logic [31:0]           MAGIC      = 32'h4153524D,
  parameter logic [ADDR_WIDTH-1:0] RAM_BASE   = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  output logic                  rom_enable,
  input  logic [7:0]            rom_data,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [7:0]            ram_data,
  output logic                  ram_wr,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  localparam int             CW     = ADDR_WIDTH + 1;
  localparam logic [CW-1:0]  SIZE_C = CW'(ROM_SIZE);
  localparam logic [CW-1:0]  HDR_C  = CW'(4);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MAGIC,
    S_COPY,
    S_DONE,
    S_ERROR
  } state_t;

  state_t                  state, state_nx;
  logic [CW-1:0]           issue_cnt, issue_nx;
  logic [CW-1:0]           recv_cnt, recv_nx;
  logic                    rd_pend, pend_nx;
  logic                    hdr_bad, bad_nx;
  logic                    drain, drain_nx;
  logic [ADDR_WIDTH-1:0]   waddr_nx;
  logic [7:0]              wdata_nx;
  logic                    wr_nx;
  logic                    issuing;
  logic                    sample;
  logic [7:0]              exp_byte;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      issue_cnt <= '0;
      recv_cnt  <= '0;
      rd_pend   <= 1'b0;
      hdr_bad   <= 1'b0;
      drain     <= 1'b0;
      ram_addr  <= '0;
      ram_data  <= '0;
      ram_wr    <= 1'b0;
    end else begin
      state     <= state_nx;
      issue_cnt <= issue_nx;
      recv_cnt  <= recv_nx;
      rd_pend   <= pend_nx;
      hdr_bad   <= bad_nx;
      drain     <= drain_nx;
      ram_addr  <= waddr_nx;
      ram_data  <= wdata_nx;
      ram_wr    <= wr_nx;
    end
  end

  always_comb begin
    issuing = 1'b0;
    if (state == S_MAGIC)     issuing = !hdr_bad && (issue_cnt < HDR_C);
    else if (state == S_COPY) issuing = (issue_cnt < SIZE_C);
    sample = rd_pend && (((state == S_MAGIC) && !hdr_bad) || (state == S_COPY));
    case (recv_cnt[1:0])
      2'd0:    exp_byte = MAGIC[31:24];
      2'd1:    exp_byte = MAGIC[23:16];
      2'd2:    exp_byte = MAGIC[15:8];
      default: exp_byte = MAGIC[7:0];
    endcase
    rom_addr   = issuing ? issue_cnt[ADDR_WIDTH-1:0] : '0;
    rom_enable = ((state == S_MAGIC) && !hdr_bad) || (state == S_COPY);
    busy       = (state == S_MAGIC) || (state == S_COPY);
    done       = (state == S_DONE);
    error      = (state == S_ERROR);
  end

  always_comb begin
    state_nx = state;
    issue_nx = issue_cnt + CW'(issuing);
    recv_nx  = recv_cnt;
    pend_nx  = issuing;
    bad_nx   = hdr_bad;
    drain_nx = drain;
    waddr_nx = ram_addr;
    wdata_nx = ram_data;
    wr_nx    = 1'b0;
    case (state)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          state_nx = S_MAGIC;
          issue_nx = '0;
          recv_nx  = '0;
          pend_nx  = 1'b0;
          bad_nx   = 1'b0;
          drain_nx = 1'b0;
        end
      end
      S_MAGIC: begin
        // After a mismatch, one cycle lets the read already in flight drain
        if (hdr_bad) begin
          pend_nx = 1'b0;
          if (drain) state_nx = S_ERROR;
          else       drain_nx = 1'b1;
        end else if (sample) begin
          if (rom_data != exp_byte) begin
            bad_nx = 1'b1;
          end else if (recv_cnt == HDR_C - CW'(1)) begin
            state_nx = S_COPY;
            issue_nx = '0;
            recv_nx  = '0;
            pend_nx  = 1'b0;
          end else begin
            recv_nx = recv_cnt + CW'(1);
          end
        end
      end
      S_COPY: begin
        if (sample) begin
          wr_nx    = 1'b1;
          wdata_nx = rom_data;
          waddr_nx = RAM_BASE + recv_cnt[ADDR_WIDTH-1:0];
          recv_nx  = recv_cnt + CW'(1);
        end
        if (ram_wr && (recv_cnt == SIZE_C)) state_nx = S_DONE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

endmodule
